// File: rtl/frame_ram_arbiter.sv
// ---------------------------------------------------------------------------
// frame_ram_arbiter
//
// Shares the single-port frame RAM between three requesters:
//   - Ethernet sender (reads), fixed top priority, unlimited burst length
//   - FCS engine (reads)      } round-robin between these two, each grant
//   - camera pixel writer     } optionally capped at MAX_BURST accesses
//
// A requester raises x_req and waits for x_gnt. While granted it may strobe
// one access per cycle (x_rd / cam_wr). Dropping x_req releases the RAM;
// every release is followed by GAP_CYCLES idle turnaround cycles before the
// next arbitration.
//
// Ports:
//   clk, reset            system clock; synchronous active-low reset
//   eth_req/rd/addr       Ethernet request, read strobe, address
//   eth_gnt, eth_valid    Ethernet owns RAM; rd_data valid for Ethernet
//   fcs_req/rd/addr       FCS request, read strobe, address
//   fcs_gnt, fcs_valid    FCS owns RAM; rd_data valid for FCS
//   cam_req/wr/addr/data  camera request, write strobe, address, data
//   cam_gnt               camera owns RAM
//   rd_data               shared read data (ram_dout passthrough)
//   ram_addr/din/wr_en    RAM control, combinational from the owner
//   ram_dout              RAM read data, one cycle after the address
//   fsm_state             current state code for debug
//   protocol_err          sticky: a strobe was seen without its own grant
// ---------------------------------------------------------------------------
module frame_ram_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int MAX_BURST  = 64,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              eth_req,
  input  logic              eth_rd,
  input  logic [ADDR_W-1:0] eth_addr,
  output logic              eth_gnt,
  output logic              eth_valid,

  input  logic              fcs_req,
  input  logic              fcs_rd,
  input  logic [ADDR_W-1:0] fcs_addr,
  output logic              fcs_gnt,
  output logic              fcs_valid,

  input  logic              cam_req,
  input  logic              cam_wr,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  output logic              cam_gnt,

  output logic [DATA_W-1:0] rd_data,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wr_en,
  input  logic [DATA_W-1:0] ram_dout,

  output logic [2:0]        fsm_state,
  output logic              protocol_err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GNT_ETH = 3'd1;
  localparam logic [2:0] ST_GNT_FCS = 3'd2;
  localparam logic [2:0] ST_GNT_CAM = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  // Burst counter must hold MAX_BURST-1; the +2 keeps the width >= 1 when
  // MAX_BURST is 0 (unlimited) and the counter is never consulted.
  localparam int CNT_W = $clog2(MAX_BURST + 2);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [CNT_W-1:0] BURST_LAST =
    (MAX_BURST == 0) ? '0 : CNT_W'(MAX_BURST - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             rr_prefer_cam;

  logic eth_acc;
  logic fcs_acc;
  logic cam_acc;
  logic burst_last;
  logic gap_last;
  logic strobe_err;

  // Grants decode straight from the state register so they are glitch-free
  // and change exactly one cycle after the arbitration decision.
  assign eth_gnt   = (state == ST_GNT_ETH);
  assign fcs_gnt   = (state == ST_GNT_FCS);
  assign cam_gnt   = (state == ST_GNT_CAM);
  assign fsm_state = state;

  assign eth_acc = eth_gnt & eth_rd;
  assign fcs_acc = fcs_gnt & fcs_rd;
  assign cam_acc = cam_gnt & cam_wr;

  // The access being accepted this cycle is the last one the grant allows.
  assign burst_last = (MAX_BURST != 0) && (burst_cnt == BURST_LAST);
  assign gap_last   = (gap_cnt == GAP_LAST);

  // A strobe from anyone not currently owning the RAM; such accesses are
  // never routed to the RAM, they only raise the sticky error.
  assign strobe_err = (eth_rd & ~eth_gnt) |
                      (fcs_rd & ~fcs_gnt) |
                      (cam_wr & ~cam_gnt);

  // RAM read data is simply forwarded; the valids say who it belongs to.
  assign rd_data = ram_dout;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise an unassigned path infers a latch.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (eth_req) begin
          state_nxt = ST_GNT_ETH;
        end else if (fcs_req && cam_req) begin
          state_nxt = rr_prefer_cam ? ST_GNT_CAM : ST_GNT_FCS;
        end else if (fcs_req) begin
          state_nxt = ST_GNT_FCS;
        end else if (cam_req) begin
          state_nxt = ST_GNT_CAM;
        end
      end
      // Ethernet is never cut short: a frame cannot pause on MII.
      ST_GNT_ETH: begin
        if (!eth_req) state_nxt = ST_GAP;
      end
      ST_GNT_FCS: begin
        if (!fcs_req || (fcs_acc && burst_last)) state_nxt = ST_GAP;
      end
      ST_GNT_CAM: begin
        if (!cam_req || (cam_acc && burst_last)) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (gap_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // RAM port mux: only the owner reaches the RAM, everything else reads 0.
  // -------------------------------------------------------------------------
  always_comb begin
    ram_addr  = '0;
    ram_din   = '0;
    ram_wr_en = 1'b0;
    case (state)
      ST_GNT_ETH: ram_addr = eth_addr;
      ST_GNT_FCS: ram_addr = fcs_addr;
      ST_GNT_CAM: begin
        ram_addr  = cam_addr;
        ram_din   = cam_data;
        ram_wr_en = cam_wr;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      burst_cnt     <= '0;
      gap_cnt       <= '0;
      rr_prefer_cam <= 1'b0;
      eth_valid     <= 1'b0;
      fcs_valid     <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      state <= state_nxt;

      // Grants are only ever entered from IDLE, so clearing there covers
      // every new grant. Ethernet accesses are not counted.
      if (state == ST_IDLE) begin
        burst_cnt <= '0;
      end else if (fcs_acc || cam_acc) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end

      // Turnaround counter restarts on each entry into GAP.
      if (state != ST_GAP) begin
        gap_cnt <= '0;
      end else if (!gap_last) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end

      // Whoever just gave up the RAM loses the next tie.
      if (state == ST_GNT_FCS && state_nxt != ST_GNT_FCS) begin
        rr_prefer_cam <= 1'b1;
      end else if (state == ST_GNT_CAM && state_nxt != ST_GNT_CAM) begin
        rr_prefer_cam <= 1'b0;
      end

      // Valid follows the accepted read by the RAM's one-cycle latency and
      // is delivered even if the grant has just dropped.
      eth_valid <= eth_acc;
      fcs_valid <= fcs_acc;

      protocol_err <= protocol_err | strobe_err;
    end
  end

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
  a_one_grant : assert property (@(posedge clk) disable iff (!reset)
    $onehot0({eth_gnt, fcs_gnt, cam_gnt}));

  a_one_valid : assert property (@(posedge clk) disable iff (!reset)
    !(eth_valid && fcs_valid));

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_ram_arbiter
//
// Drives directed scenarios into frame_ram_arbiter with a behavioural
// 2048x8 RAM attached. Issued reads/writes push their expected outcome into
// queues; a monitor on the falling edge pops and compares whenever the DUT
// presents a valid or a RAM write. Grant timing, state codes and the error
// flag are compared directly from the stimulus thread.
// ---------------------------------------------------------------------------
module tb_frame_ram_arbiter;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 8;
  localparam int MAX_BURST  = 4;
  localparam int GAP_CYCLES = 1;
  localparam int DEPTH      = 2048;

  localparam int SRC_ETH = 0;
  localparam int SRC_FCS = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              eth_req = 1'b0, eth_rd = 1'b0;
  logic [ADDR_W-1:0] eth_addr = '0;
  logic              eth_gnt, eth_valid;
  logic              fcs_req = 1'b0, fcs_rd = 1'b0;
  logic [ADDR_W-1:0] fcs_addr = '0;
  logic              fcs_gnt, fcs_valid;
  logic              cam_req = 1'b0, cam_wr = 1'b0;
  logic [ADDR_W-1:0] cam_addr = '0;
  logic [DATA_W-1:0] cam_data = '0;
  logic              cam_gnt;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_wr_en;
  logic [DATA_W-1:0] ram_dout = '0;
  logic [2:0]        fsm_state;
  logic              protocol_err;

  always #5 clk = ~clk;

  frame_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MAX_BURST(MAX_BURST), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .eth_req(eth_req), .eth_rd(eth_rd), .eth_addr(eth_addr),
    .eth_gnt(eth_gnt), .eth_valid(eth_valid),
    .fcs_req(fcs_req), .fcs_rd(fcs_rd), .fcs_addr(fcs_addr),
    .fcs_gnt(fcs_gnt), .fcs_valid(fcs_valid),
    .cam_req(cam_req), .cam_wr(cam_wr), .cam_addr(cam_addr),
    .cam_data(cam_data), .cam_gnt(cam_gnt),
    .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wr_en(ram_wr_en),
    .ram_dout(ram_dout),
    .fsm_state(fsm_state), .protocol_err(protocol_err)
  );

  // Initial frame content: 0x11..0x14 at 0..3, an address-derived pattern
  // elsewhere.
  function automatic logic [DATA_W-1:0] pat(int a);
    if (a < 4) return DATA_W'(8'h11 + a);
    return DATA_W'((a * 7 + 3) & 255);
  endfunction

  // Behavioural RAM: read-first, one-cycle synchronous read latency.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= pat(a);
      loaded <= 1'b1;
    end else begin
      if (ram_wr_en) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int                src;
    logic [DATA_W-1:0] data;
    int                cyc;
  } rd_exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  rd_exp_t           rd_q [$];
  wr_exp_t           wr_q [$];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  always @(negedge clk) begin
    rd_exp_t e;
    wr_exp_t w;
    int      src;
    if (eth_valid || fcs_valid) begin
      check("one_valid", 32'(!(eth_valid && fcs_valid)), 32'd1);
      src = eth_valid ? SRC_ETH : SRC_FCS;
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid @cycle %0d: got src %0d data 0x%0h, expected none",
                 cyc, src, rd_data);
      end else begin
        e = rd_q.pop_front();
        check("rd_src", 32'(src), 32'(e.src));
        check("rd_data", 32'(rd_data), 32'(e.data));
        check("rd_latency", 32'(cyc), 32'(e.cyc + 1));
      end
    end
    if (ram_wr_en) begin
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write @cycle %0d: got addr 0x%0h data 0x%0h, expected none",
                 cyc, ram_addr, ram_din);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(w.addr));
        check("wr_data", 32'(ram_din), 32'(w.data));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes();
    eth_rd = 1'b0;
    fcs_rd = 1'b0;
    cam_wr = 1'b0;
  endtask

  task automatic issue_eth_rd(input logic [ADDR_W-1:0] a);
    eth_rd   = 1'b1;
    eth_addr = a;
    rd_q.push_back('{SRC_ETH, exp_mem[a], cyc});
  endtask

  task automatic issue_fcs_rd(input logic [ADDR_W-1:0] a);
    fcs_rd   = 1'b1;
    fcs_addr = a;
    rd_q.push_back('{SRC_FCS, exp_mem[a], cyc});
  endtask

  task automatic issue_cam_wr(input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
    cam_wr   = 1'b1;
    cam_addr = a;
    cam_data = d;
    exp_mem[a] = d;
    wr_q.push_back('{a, d});
  endtask

  // Expected state per cycle of the FCS/CAM alternation scenario.
  logic [2:0] alt_st [18] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd0,
                              3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0,
                              3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd0};
  logic [ADDR_W-1:0] alt_fcs_addr [8] = '{11'h000, 11'h001, 11'h002, 11'h003,
                                          11'h010, 11'h100, 11'h101, 11'h102};

  initial begin
    int fi;
    int ci;
    int eth_drop;
    int fcs_seen;

    for (int a = 0; a < DEPTH; a++) exp_mem[a] = pat(a);

    // ---- reset state ----
    step();
    step();
    check("rst_state", 32'(fsm_state), 32'd0);
    check("rst_gnts", 32'({eth_gnt, fcs_gnt, cam_gnt}), 32'd0);
    check("rst_valids", 32'({eth_valid, fcs_valid}), 32'd0);
    check("rst_perr", 32'(protocol_err), 32'd0);
    check("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_din", 32'(ram_din), 32'd0);

    // ---- single camera write ----
    reset   = 1'b1;
    cam_req = 1'b1;
    step();
    check("cam_gnt_lat1", 32'(cam_gnt), 32'd1);
    check("cam_state", 32'(fsm_state), 32'd3);
    issue_cam_wr(11'h010, 8'hA5);
    cam_req = 1'b0;            // release in the same cycle as the strobe
    #1;
    check("cam_wr_en", 32'(ram_wr_en), 32'd1);
    check("cam_wr_addr", 32'(ram_addr), 32'h010);
    check("cam_wr_din", 32'(ram_din), 32'hA5);
    step();
    idle_strobes();
    check("cam_rel_gap", 32'(fsm_state), 32'd4);
    check("cam_rel_gnt", 32'(cam_gnt), 32'd0);
    step();
    check("cam_rel_idle", 32'(fsm_state), 32'd0);

    // ---- FCS/CAM round robin with MAX_BURST=4 ----
    fcs_req = 1'b1;
    cam_req = 1'b1;
    fi = 0;
    ci = 0;
    for (int k = 0; k < 18; k++) begin
      step();
      idle_strobes();
      check("alt_state", 32'(fsm_state), 32'(alt_st[k]));
      if (alt_st[k] == 3'd2) begin
        issue_fcs_rd(alt_fcs_addr[fi]);
        fi++;
      end else if (alt_st[k] == 3'd3) begin
        issue_cam_wr(ADDR_W'(11'h100 + ci), DATA_W'(8'hC0 + ci));
        ci++;
      end
      if (k == 15) begin
        fcs_req = 1'b0;
        cam_req = 1'b0;
      end
    end

    // ---- Ethernet during a camera grant: no preemption ----
    cam_req = 1'b1;
    step();
    check("pre_cam_gnt", 32'(cam_gnt), 32'd1);
    eth_req = 1'b1;
    issue_cam_wr(11'h200, 8'h5A);
    step();
    idle_strobes();
    check("nopreempt_eth1", 32'(eth_gnt), 32'd0);
    check("nopreempt_cam1", 32'(cam_gnt), 32'd1);
    issue_cam_wr(11'h201, 8'h5B);
    step();
    idle_strobes();
    check("nopreempt_eth2", 32'(eth_gnt), 32'd0);
    check("nopreempt_cam2", 32'(cam_gnt), 32'd1);
    cam_req = 1'b0;
    step();                    // camera grant has dropped here
    check("eth_wait_gap", 32'(fsm_state), 32'd4);
    check("eth_wait_gnt0", 32'(eth_gnt), 32'd0);
    for (int g = 1; g <= GAP_CYCLES; g++) begin
      step();
      check("eth_wait_gntN", 32'(eth_gnt), 32'd0);
    end
    step();                    // GAP_CYCLES+1 cycles after the camera release
    check("eth_gnt_rise", 32'(eth_gnt), 32'd1);

    // ---- long Ethernet burst, FCS requesting throughout ----
    fcs_req  = 1'b1;
    eth_drop = 0;
    fcs_seen = 0;
    for (int i = 0; i < 1400; i++) begin
      if (!eth_gnt) eth_drop++;
      if (fcs_gnt) fcs_seen++;
      issue_eth_rd(ADDR_W'((i * 5 + 7) % DEPTH));
      if (i == 1399) begin
        eth_req = 1'b0;
        fcs_req = 1'b0;
      end
      step();
      idle_strobes();
    end
    check("eth_no_release", 32'(eth_drop), 32'd0);
    check("eth_no_fcs", 32'(fcs_seen), 32'd0);
    check("eth_rel_gap", 32'(fsm_state), 32'd4);
    step();
    check("eth_rel_idle", 32'(fsm_state), 32'd0);
    check("perr_clean", 32'(protocol_err), 32'd0);

    // ---- strobe without grant ----
    eth_rd   = 1'b1;
    eth_addr = 11'h055;
    #1;
    check("perr_addr0", 32'(ram_addr), 32'd0);
    check("perr_no_wr", 32'(ram_wr_en), 32'd0);
    step();
    idle_strobes();
    check("perr_set", 32'(protocol_err), 32'd1);
    check("perr_no_valid", 32'(eth_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("perr_sticky", 32'(protocol_err), 32'd1);
    end

    // ---- reset mid FCS burst ----
    fcs_req = 1'b1;            // short FCS grant: tie would now go to camera
    step();
    check("pre_rst_fcs", 32'(fcs_gnt), 32'd1);
    fcs_req = 1'b0;
    step();
    step();
    fcs_req = 1'b1;
    step();
    check("rst_mid_fcs", 32'(fcs_gnt), 32'd1);
    fcs_rd   = 1'b1;           // read outstanding when reset hits
    fcs_addr = 11'h003;
    reset    = 1'b0;
    step();
    idle_strobes();
    check("rst_mid_gnts", 32'({eth_gnt, fcs_gnt, cam_gnt}), 32'd0);
    check("rst_mid_valid", 32'(fcs_valid), 32'd0);
    check("rst_mid_state", 32'(fsm_state), 32'd0);
    check("rst_mid_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_mid_perr", 32'(protocol_err), 32'd0);
    fcs_req = 1'b1;
    cam_req = 1'b1;
    step();
    reset = 1'b1;
    step();
    check("post_rst_fcs", 32'(fcs_gnt), 32'd1);
    check("post_rst_cam", 32'(cam_gnt), 32'd0);
    fcs_req = 1'b0;
    cam_req = 1'b0;

    // ---- drain ----
    for (int i = 0; i < 20 && (rd_q.size() != 0 || wr_q.size() != 0); i++) step();
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
